slurm32_cpu_writeback: RTL and testbench
========================================

Name: slurm32_cpu_writeback

Overview:
- Writeback stage for the SLURM32 core. It drives the single write port (regIn_sel/regIn_data) of the CPU register file.
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results;
  - in-order memory load returns, tracked in a small load queue.
- Provides a load-use hazard flag for decode. Register 0 is the "no write" select, because the register file writes every cycle and always reads 0 from r0.

Parameters:
- REG_BITS, 8: register index width (2**REG_BITS registers).
- BITS, 32: data width.
- LQ_DEPTH, 4: outstanding-load queue depth; power of two, at least 2.

Ports:
- CLK  in  1  clock.
- RSTb  in  1  synchronous reset, active-high. The name follows codebase port naming; the polarity is active-high regardless of the suffix.
- alu_valid  in  1  ALU result present.
- alu_reg  in  REG_BITS  ALU destination register.
- alu_data  in  BITS  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- ld_issue_valid  in  1  load issued to memory.
- ld_issue_reg  in  REG_BITS  load destination register.
- ld_issue_ready  out  1  load queue can accept an issue.
- mem_rvalid  in  1  load data returning, in issue order; cannot be stalled.
- mem_rdata  in  BITS  load data.
- hz_regA  in  REG_BITS  decode source A index.
- hz_regB  in  REG_BITS  decode source B index.
- hz_stall  out  1  a source register has a pending write.
- lq_err  out  1  sticky flag: load return arrived with the queue empty.
- regIn_sel  out  REG_BITS  register file write select.
- regIn_data  out  BITS  register file write data.

Behaviour:
- Reset (RSTb=1 at a CLK edge):
  - regIn_sel=0, regIn_data=0, lq_err=0;
  - load queue emptied (count=0, read/write pointers 0);
  - reset mid-operation discards all queued loads.
- Write arbitration, evaluated each cycle:
  - Priority 1: mem_rvalid with a non-empty queue. The write is queue head reg + mem_rdata; the head is popped.
  - Priority 2: alu_valid. The write is alu_reg + alu_data.
  - Otherwise the write is reg 0 with data 0.
- alu_ready = !(mem_rvalid && count!=0). This is combinational. When deasserted, the ALU holds alu_reg and alu_data stable.
- Latency: the winning result appears on regIn_sel/regIn_data one CLK after acceptance. They are registered, so they hold for exactly one cycle.
- Destination reg 0:
  - a load to r0 is queued (this preserves return ordering) and writes r0, which is harmless;
  - an ALU write to r0 is accepted and is equally harmless.
- Load queue:
  - FIFO of destination indices; count ranges 0..LQ_DEPTH;
  - pointers wrap modulo LQ_DEPTH;
  - push when ld_issue_valid && ld_issue_ready;
  - ld_issue_ready = (count != LQ_DEPTH), from registered state only;
  - simultaneous push and pop: count unchanged and both pointers advance;
  - at full with a return in the same cycle, the pop happens but the issue is not accepted, because ready was 0.
- mem_rvalid with count==0: the return is ignored (no write, ALU unaffected) and lq_err is set until reset.
- hz_stall, combinational, asserts when hz_regA or hz_regB is nonzero and either:
  - it equals any valid queue entry, including the head being popped this cycle; or
  - (bypass disabled only) it equals the currently registered regIn_sel.
- Reg 0 never causes a stall.

Optional Feature:
- Macro SLURM32_WB_BYPASS_EN.
- When defined:
  - adds outputs byp_valid (1), byp_sel (REG_BITS) and byp_data (BITS);
  - byp_sel and byp_data equal regIn_sel and regIn_data;
  - byp_valid = (regIn_sel != 0);
  - hz_stall omits the in-flight regIn_sel term, because decode forwards from the bypass instead.
- When undefined:
  - no bypass ports;
  - hz_stall includes the regIn_sel match term.

Test Plan:
- Reset, then alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF for one cycle -> next cycle regIn_sel=5, regIn_data=0xDEADBEEF; the cycle after, regIn_sel=0.
- Issue loads to r3 and r7, then return 0x11 and 0x22 on consecutive cycles -> writes r3=0x11, then r7=0x22 in order; hz_stall is set for hz_regA=7 until r7 pops.
- mem_rvalid and alu_valid in the same cycle with one load queued -> alu_ready=0; the load writes first and the ALU write lands one cycle later.
- Issue LQ_DEPTH=4 loads -> ld_issue_ready=0. Then return plus issue in the same cycle -> pop only, count=3, ready=1 the next cycle.
- mem_rvalid with an empty queue -> no write and lq_err=1, held across further traffic until RSTb=1 clears it and the queue.
- Optional feature:
  - with SLURM32_WB_BYPASS_EN, ALU write r9 -> byp_valid=1, byp_sel=9 and hz_stall=0 for hz_regA=9;
  - without the macro, the same stimulus gives hz_stall=1 that cycle.

Source files
------------

// File: rtl/slurm32_cpu_writeback.sv
// SLURM32 writeback stage: merges ALU results and in-order load returns into
// the single register-file write port, tracks outstanding loads for hazards.
// Optional feature macro: SLURM32_WB_BYPASS_EN (adds byp_valid/byp_sel/byp_data
// and drops the in-flight write term from hz_stall).
module slurm32_cpu_writeback #(
  parameter int unsigned REG_BITS = 8,
  parameter int unsigned BITS     = 32,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic                alu_valid,
  input  logic [REG_BITS-1:0] alu_reg,
  input  logic [BITS-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                ld_issue_valid,
  input  logic [REG_BITS-1:0] ld_issue_reg,
  output logic                ld_issue_ready,
  input  logic                mem_rvalid,
  input  logic [BITS-1:0]     mem_rdata,
  input  logic [REG_BITS-1:0] hz_regA,
  input  logic [REG_BITS-1:0] hz_regB,
  output logic                hz_stall,
  output logic                lq_err,
`ifdef SLURM32_WB_BYPASS_EN
  output logic                byp_valid,
  output logic [REG_BITS-1:0] byp_sel,
  output logic [BITS-1:0]     byp_data,
`endif
  output logic [REG_BITS-1:0] regIn_sel,
  output logic [BITS-1:0]     regIn_data
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

  logic [REG_BITS-1:0] lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [LQ_DEPTH-1:0] lq_vld;

  logic pop;
  logic push;
  logic ret_empty;
  logic hz_a;
  logic hz_b;

  // Load return pops the head only when something is outstanding
  assign pop       = mem_rvalid && (count != '0);
  assign ret_empty = mem_rvalid && (count == '0);
  assign alu_ready = !pop;

  // Issue readiness depends on registered occupancy only
  assign ld_issue_ready = (count != CNT_W'(LQ_DEPTH));
  assign push           = ld_issue_valid && ld_issue_ready;

  // Mark queue slots that lie within [rd_ptr, rd_ptr+count)
  always_comb begin
    lq_vld = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count) begin
        lq_vld[i] = 1'b1;
      end
    end
  end

  // Source-register hazard against queued loads and the in-flight write
  always_comb begin
    hz_a = 1'b0;
    hz_b = 1'b0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (lq_vld[i] && (lq_mem[i] == hz_regA)) hz_a = 1'b1;
      if (lq_vld[i] && (lq_mem[i] == hz_regB)) hz_b = 1'b1;
    end
`ifndef SLURM32_WB_BYPASS_EN
    if (regIn_sel == hz_regA) hz_a = 1'b1;
    if (regIn_sel == hz_regB) hz_b = 1'b1;
`endif
    hz_stall = ((hz_regA != '0) && hz_a) || ((hz_regB != '0) && hz_b);
  end

  // Load queue storage and pointers
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < LQ_DEPTH; i++) lq_mem[i] <= '0;
    end else begin
      if (push) begin
        lq_mem[wr_ptr] <= ld_issue_reg;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Registered write arbitration: load return beats ALU, else r0/0
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      regIn_sel  <= '0;
      regIn_data <= '0;
    end else if (pop) begin
      regIn_sel  <= lq_mem[rd_ptr];
      regIn_data <= mem_rdata;
    end else if (alu_valid) begin
      regIn_sel  <= alu_reg;
      regIn_data <= alu_data;
    end else begin
      regIn_sel  <= '0;
      regIn_data <= '0;
    end
  end

  // Sticky error for a return with nothing outstanding
  always_ff @(posedge CLK) begin
    if (RSTb) lq_err <= 1'b0;
    else if (ret_empty) lq_err <= 1'b1;
  end

`ifdef SLURM32_WB_BYPASS_EN
  // Bypass valid tracks a non-r0 write, registered alongside regIn_sel
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      byp_valid <= 1'b0;
    end else if (pop) begin
      byp_valid <= (lq_mem[rd_ptr] != '0);
    end else if (alu_valid) begin
      byp_valid <= (alu_reg != '0);
    end else begin
      byp_valid <= 1'b0;
    end
  end

  assign byp_sel  = regIn_sel;
  assign byp_data = regIn_data;
`endif

endmodule

// File: tb/tb_slurm32_cpu_writeback.sv
// Self-checking bench for slurm32_cpu_writeback (default build or with
// SLURM32_WB_BYPASS_EN defined).
module tb_slurm32_cpu_writeback;

  localparam int unsigned REG_BITS = 8;
  localparam int unsigned BITS     = 32;
  localparam int unsigned LQ_DEPTH = 4;
`ifdef SLURM32_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [REG_BITS-1:0] sel;
    logic [BITS-1:0]     data;
  } wb_t;

  logic                CLK = 1'b0;
  logic                RSTb;
  logic                alu_valid;
  logic [REG_BITS-1:0] alu_reg;
  logic [BITS-1:0]     alu_data;
  logic                alu_ready;
  logic                ld_issue_valid;
  logic [REG_BITS-1:0] ld_issue_reg;
  logic                ld_issue_ready;
  logic                mem_rvalid;
  logic [BITS-1:0]     mem_rdata;
  logic [REG_BITS-1:0] hz_regA;
  logic [REG_BITS-1:0] hz_regB;
  logic                hz_stall;
  logic                lq_err;
  logic [REG_BITS-1:0] regIn_sel;
  logic [BITS-1:0]     regIn_data;
`ifdef SLURM32_WB_BYPASS_EN
  logic                byp_valid;
  logic [REG_BITS-1:0] byp_sel;
  logic [BITS-1:0]     byp_data;
`endif

  slurm32_cpu_writeback #(
    .REG_BITS(REG_BITS), .BITS(BITS), .LQ_DEPTH(LQ_DEPTH)
  ) dut (
    .CLK(CLK), .RSTb(RSTb),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_reg(ld_issue_reg),
    .ld_issue_ready(ld_issue_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hz_regA(hz_regA), .hz_regB(hz_regB), .hz_stall(hz_stall),
    .lq_err(lq_err),
`ifdef SLURM32_WB_BYPASS_EN
    .byp_valid(byp_valid), .byp_sel(byp_sel), .byp_data(byp_data),
`endif
    .regIn_sel(regIn_sel), .regIn_data(regIn_data)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [REG_BITS-1:0] m_lq[$];
  logic                m_err = 1'b0;
  logic [REG_BITS-1:0] m_last = '0;
  wb_t                 exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic hz_model(input logic [REG_BITS-1:0] r);
    if (r == '0) return 1'b0;
    foreach (m_lq[i]) if (m_lq[i] == r) return 1'b1;
    if (!BYP && (r == m_last)) return 1'b1;
    return 1'b0;
  endfunction

  // Check combinational outputs, predict the write, advance one clock, compare
  task automatic step();
    logic pop;
    logic push;
    wb_t  e;
    #1;
    pop  = mem_rvalid && (m_lq.size() != 0);
    push = ld_issue_valid && (m_lq.size() != LQ_DEPTH);
    if (!RSTb) begin
      check("alu_ready", 64'(alu_ready), 64'(!pop));
      check("ld_issue_ready", 64'(ld_issue_ready), 64'(m_lq.size() != LQ_DEPTH));
      check("hz_stall", 64'(hz_stall), 64'(hz_model(hz_regA) || hz_model(hz_regB)));
    end
    e = '0;
    if (RSTb) begin
      m_lq.delete();
      m_err = 1'b0;
    end else begin
      if (pop) begin
        e.sel  = m_lq.pop_front();
        e.data = mem_rdata;
      end else if (alu_valid) begin
        e.sel  = alu_reg;
        e.data = alu_data;
      end
      if (mem_rvalid && !pop) m_err = 1'b1;
      if (push) m_lq.push_back(ld_issue_reg);
    end
    m_last = e.sel;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("regIn_sel", 64'(regIn_sel), 64'(e.sel));
      check("regIn_data", 64'(regIn_data), 64'(e.data));
    end
    check("lq_err", 64'(lq_err), 64'(m_err));
`ifdef SLURM32_WB_BYPASS_EN
    check("byp_valid", 64'(byp_valid), 64'(regIn_sel != '0));
    check("byp_sel", 64'(byp_sel), 64'(e.sel));
    check("byp_data", 64'(byp_data), 64'(e.data));
`endif
  endtask

  task automatic idle_inputs();
    RSTb = 1'b0; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_issue_valid = 1'b0; ld_issue_reg = '0; mem_rvalid = 1'b0;
    mem_rdata = '0; hz_regA = '0; hz_regB = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTb = 1'b1;
    step();
    step();
    RSTb = 1'b0;
  endtask

  initial begin
    logic held;
    idle_inputs();
    @(posedge CLK);
    #1;
    do_reset();

    // Single ALU write, then idle
    alu_valid = 1'b1; alu_reg = 8'd5; alu_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    step();

    // Two loads returning in order, hazard on r7 until it pops
    hz_regA = 8'd7;
    ld_issue_valid = 1'b1; ld_issue_reg = 8'd3; step();
    ld_issue_reg = 8'd7; step();
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h11; step();
    mem_rdata = 32'h22; step();
    mem_rvalid = 1'b0; step();
    step();
    hz_regA = '0;

    // Load return collides with an ALU result; ALU holds until accepted
    ld_issue_valid = 1'b1; ld_issue_reg = 8'd4; step();
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    alu_valid = 1'b1; alu_reg = 8'd6; alu_data = 32'h66; step();
    mem_rvalid = 1'b0; step();
    idle_inputs(); step();

    // Fill the queue, then return plus issue at full
    ld_issue_valid = 1'b1;
    ld_issue_reg = 8'd1; step();
    ld_issue_reg = 8'd2; step();
    ld_issue_reg = 8'd8; step();
    ld_issue_reg = 8'd10; step();
    ld_issue_reg = 8'd11; mem_rvalid = 1'b1; mem_rdata = 32'hA1; step();
    ld_issue_valid = 1'b0; mem_rvalid = 1'b0; hz_regB = 8'd11; step();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hA2; step();
    mem_rdata = 32'hA3; step();
    mem_rdata = 32'hA4; step();
    idle_inputs(); step();

    // Load to r0 keeps ordering and writes r0
    ld_issue_valid = 1'b1; ld_issue_reg = 8'd0; step();
    ld_issue_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF; hz_regA = 8'd0; step();
    idle_inputs(); step();

    // ALU write to r9, then probe hazard on r9 while it is in flight
    alu_valid = 1'b1; alu_reg = 8'd9; alu_data = 32'h9999; step();
    idle_inputs(); hz_regA = 8'd9; step();
    idle_inputs(); step();

    // Return with an empty queue sets the sticky error
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD; alu_valid = 1'b1; alu_reg = 8'd12;
    alu_data = 32'h12; step();
    idle_inputs();
    ld_issue_valid = 1'b1; ld_issue_reg = 8'd13; step();
    ld_issue_reg = 8'd14; step();
    idle_inputs(); step();
    // Reset mid-operation discards the two queued loads and the error
    do_reset();
    hz_regA = 8'd13; step();
    mem_rvalid = 1'b1; mem_rdata = 32'h77; step();
    do_reset();

    // Randomised traffic with ALU hold-while-not-ready behaviour
    held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_reg   = REG_BITS'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      ld_issue_valid = ($urandom_range(0, 2) == 0);
      ld_issue_reg   = REG_BITS'($urandom_range(0, 15));
      mem_rvalid     = ($urandom_range(0, 2) == 0) && (m_lq.size() != 0 || n > 380);
      mem_rdata      = $urandom;
      hz_regA        = REG_BITS'($urandom_range(0, 15));
      hz_regB        = REG_BITS'($urandom_range(0, 15));
      held = alu_valid && mem_rvalid && (m_lq.size() != 0);
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
